// File: rtl/baud_pkg.sv
// baud_pkg: baud rate enumeration and fixed-point divisor calculation for the baud generator.
package baud_pkg;
  typedef enum logic [2:0] {B1200, B2400, B4800, B9600, B19200, B38400, B57600, B115200} baud_e;

  function automatic longint baud_hz(input baud_e b);
    return b == B115200 ? 64'd115200 : b == B57600 ? 64'd57600 : longint'(1200) << b;
  endfunction

  // Divisor in units of 2^-frac_w, rounded to nearest; a rounding carry lands in the integer part naturally.
  function automatic longint calc_div(input longint clk_hz, input longint baud, input longint os,
                                      input longint frac_w);
    return ((clk_hz << (frac_w + 1)) / (baud * os) + 1) >> 1;
  endfunction
endpackage

// File: rtl/frac_period_div.sv
// frac_period_div: fractional-N period counter; emits a tick at the end of each period and a reload strobe.
module frac_period_div #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              run,
  input  logic              clr,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick,
  output logic              reload
);
  logic              r_run;
  logic [CNT_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W:0]   w_sum;
  logic              w_zero;

  assign w_zero = r_cnt == '0;
  assign tick   = run && r_run && w_zero && !clr;
  assign reload = run && (!r_run || w_zero || clr);
  assign w_sum  = {1'b0, clr ? {FRAC_W{1'b0}} : r_acc} + {1'b0, div_frac};

  always_ff @(posedge clock or posedge rst)
    if (rst) {r_run, r_cnt, r_acc} <= '0;
    else if (!run) {r_run, r_cnt, r_acc} <= '0;
    else begin
      r_run <= 1'b1;
      if (!reload) r_cnt <= r_cnt - CNT_W'(1);
      else if (div_int == '0) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_acc <= w_sum[FRAC_W-1:0];
        r_cnt <= div_int + CNT_W'(w_sum[FRAC_W]) - CNT_W'(1);
      end
    end
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: UART baud generator with oversample, mid-bit and end-of-bit ticks plus a baud square wave.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int OVERSAMPLE  = 16,
  parameter int CNT_W       = 16,
  parameter int FRAC_W      = 4
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2:0]              baud_sel,
  input  logic                    div_ovr_en,
  input  logic [CNT_W+FRAC_W-1:0] div_ovr,
  input  logic                    sync_clear,
  output logic                    tick_os,
  output logic                    tick_mid,
  output logic                    tick_bit,
  output logic                    baud_clk,
  output logic                    rate_valid
);
  localparam int DW = CNT_W + FRAC_W;
  localparam int OW = $clog2(OVERSAMPLE);

  logic [DW-1:0] w_tab [8];
  logic [DW-1:0] w_sel, r_act;
  logic [OW-1:0] r_os;
  logic          w_tick, w_reload, r_bclk;

  for (genvar g = 0; g < 8; g++) begin : g_tab
    localparam logic [DW-1:0] D = DW'(calc_div(longint'(CLK_FREQ_HZ), baud_hz(baud_e'(g)),
                                               longint'(OVERSAMPLE), longint'(FRAC_W)));
    assign w_tab[g] = D;
  end

  assign w_sel = div_ovr_en ? div_ovr : w_tab[baud_sel];

  frac_period_div #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) u_div (
    .clock    (clock),
    .rst      (rst),
    .run      (en),
    .clr      (sync_clear),
    .div_int  (w_sel[DW-1:FRAC_W]),
    .div_frac (w_sel[FRAC_W-1:0]),
    .tick     (w_tick),
    .reload   (w_reload)
  );

  // Ticks are qualified by the divisor that defined the period now ending.
  assign tick_os    = w_tick && r_act[DW-1:FRAC_W] != '0;
  assign tick_mid   = tick_os && r_os == OW'(OVERSAMPLE / 2 - 1);
  assign tick_bit   = tick_os && r_os == OW'(OVERSAMPLE - 1);
  assign baud_clk   = r_bclk;
  assign rate_valid = !rst && ((en ? r_act[DW-1:FRAC_W] : w_sel[DW-1:FRAC_W]) != '0);

  always_ff @(posedge clock or posedge rst)
    if (rst) {r_act, r_os, r_bclk} <= '0;
    else if (!en) {r_act, r_os, r_bclk} <= '0;
    else begin
      if (w_reload) r_act <= w_sel;
      if (sync_clear) begin
        r_os   <= '0;
        r_bclk <= 1'b0;
      end else if (tick_os) begin
        r_os   <= tick_bit ? '0 : r_os + OW'(1);
        r_bclk <= (tick_mid || tick_bit) ? ~r_bclk : r_bclk;
      end
    end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed vectors and corner sequences for baud_tick_gen at 50 MHz and 1.8432 MHz.
module tb_baud_tick_gen;
  logic        clock = 0, rst = 1, en = 0, div_ovr_en = 0, sync_clear = 0;
  logic [2:0]  baud_sel = 0;
  logic [19:0] div_ovr = 0;
  logic        t_os, t_mid, t_bit, bclk, rv;
  logic        s_os, s_mid, s_bit, s_bclk, s_rv;
  int          n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  baud_tick_gen dut (
    .clock(clock), .rst(rst), .en(en), .baud_sel(baud_sel), .div_ovr_en(div_ovr_en),
    .div_ovr(div_ovr), .sync_clear(sync_clear), .tick_os(t_os), .tick_mid(t_mid),
    .tick_bit(t_bit), .baud_clk(bclk), .rate_valid(rv)
  );

  baud_tick_gen #(.CLK_FREQ_HZ(1843200)) dut_s (
    .clock(clock), .rst(rst), .en(en), .baud_sel(baud_sel), .div_ovr_en(div_ovr_en),
    .div_ovr(div_ovr), .sync_clear(sync_clear), .tick_os(s_os), .tick_mid(s_mid),
    .tick_bit(s_bit), .baud_clk(s_bclk), .rate_valid(s_rv)
  );

  typedef struct {
    logic [2:0]  sel;
    logic        ovr_en;
    logic [19:0] ovr;
    int          p;
    int          ps;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Call right after driving en=1 at a falling edge; returns cycles to first tick_os of each DUT.
  task automatic first_tick(output int p, output int ps);
    p  = -1;
    ps = -1;
    for (int k = 1; k <= 3000 && (p < 0 || ps < 0); k++) begin
      @(negedge clock);
      if (t_os && p < 0) p = k;
      if (s_os && ps < 0) ps = k;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   p, ps, last, nb, nso, nsb, nrise, n, m;
    int   q[$];
    logic pb;
    vecs[0] = '{3'd0, 1'b0, 20'h0,  2604, 96};
    vecs[1] = '{3'd3, 1'b0, 20'h0,  325,  12};
    vecs[2] = '{3'd5, 1'b0, 20'h0,  81,   3};
    vecs[3] = '{3'd6, 1'b0, 20'h0,  54,   2};
    vecs[4] = '{3'd7, 1'b0, 20'h0,  27,   1};
    vecs[5] = '{3'd0, 1'b1, 20'h50, 5,    5};
    vecs[6] = '{3'd0, 1'b1, 20'h21, 2,    2};
    vecs[7] = '{3'd0, 1'b1, 20'h3F, 3,    3};

    repeat (2) @(negedge clock);
    check("reset_outputs", {t_os, t_mid, t_bit, bclk, rv}, 5'b0);
    check("reset_outputs_s", {s_os, s_mid, s_bit, s_bclk, s_rv}, 5'b0);
    rst = 0;
    @(negedge clock);
    check("idle_rate_valid", rv, 1);

    foreach (vecs[i]) begin
      en = 0;
      baud_sel = vecs[i].sel;
      div_ovr_en = vecs[i].ovr_en;
      div_ovr = vecs[i].ovr;
      @(negedge clock);
      check("vec_idle", {t_os, bclk, rv}, 3'b001);
      en = 1;
      first_tick(p, ps);
      check("vec_latency", p, vecs[i].p);
      check("vec_latency_s", ps, vecs[i].ps);
      check("vec_rate_valid", rv, 1);
    end

    // 9600 baud on both clocks: fractional periods at 50 MHz, exact 12-cycle periods at 1.8432 MHz
    en = 0; div_ovr_en = 0; baud_sel = 3;
    @(negedge clock);
    en = 1;
    last = 0; nb = 0; nso = 0; nsb = 0; nrise = 0; pb = 0;
    for (int c = 1; c <= 10500; c++) begin
      @(negedge clock);
      if (t_os) begin
        if (last > 0) check("os_gap_325_326", (c - last == 325) || (c - last == 326), 1);
        last = c;
        q.push_back(c);
        if (q.size() == 17) begin
          check("os16_window", q[16] - q[0], 5208);
          void'(q.pop_front());
        end
      end
      if (t_bit) begin
        nb++;
        check("bit_time", c, 5208 * nb);
      end
      if (s_os) begin
        nso++;
        check("s_os_time", c, 12 * nso);
      end
      if (s_mid) check("s_mid_time", c, 192 * nsb + 96);
      if (s_bit) begin
        nsb++;
        check("s_bit_time", c, 192 * nsb);
      end
      if (s_bclk && !pb) begin
        check("s_bclk_rise", c, 192 * nrise + 97);
        nrise++;
      end
      pb = s_bclk;
    end
    check("bit_count", nb, 2);
    check("s_os_count", nso, 875);
    check("s_bit_count", nsb, 54);
    check("s_bclk_rises", nrise, 55);

    // divisor override 0 then 1.0
    en = 0; div_ovr_en = 1; div_ovr = 20'h0;
    @(negedge clock);
    en = 1;
    n = 0;
    repeat (40) begin
      @(negedge clock);
      n += int'(t_os);
    end
    check("ovr0_ticks", n, 0);
    check("ovr0_rate_valid", rv, 0);
    div_ovr = 20'h10;
    repeat (3) @(negedge clock);
    n = 0; m = 0;
    repeat (32) begin
      @(negedge clock);
      n += int'(t_os);
      m += int'(t_bit);
    end
    check("ovr1_ticks", n, 32);
    check("ovr1_bits", m, 2);
    check("ovr1_rate_valid", rv, 1);

    // rate switch 9600 -> 115200 in the middle of a period
    en = 0; div_ovr_en = 0; baud_sel = 3;
    @(negedge clock);
    en = 1;
    first_tick(p, ps);
    check("sw_first", p, 325);
    n = 0;
    for (int c = 1; c <= 500 && n < 3; c++) begin
      @(negedge clock);
      if (c == 100) baud_sel = 7;
      if (t_os) begin
        n++;
        check("sw_tick_time", c, n == 1 ? 326 : 326 + 27 * (n - 1));
      end
    end
    check("sw_tick_count", n, 3);

    // sync_clear coinciding with the os_cnt=7 tick at 1.8432 MHz
    en = 0; baud_sel = 3;
    @(negedge clock);
    en = 1;
    repeat (96) @(negedge clock);
    check("pre_clear_tick_mid", {s_os, s_mid}, 2'b11);
    sync_clear = 1;
    #1;
    check("clear_suppress", {s_os, s_mid, s_bit}, 3'b000);
    @(negedge clock);
    sync_clear = 0;
    p = -1; ps = -1;
    for (int c = 2; c <= 100; c++) begin
      @(negedge clock);
      if (s_os && p < 0) p = c;
      if (s_mid && ps < 0) ps = c;
    end
    check("clear_first_tick", p, 12);
    check("clear_first_mid", ps, 96);
    check("pre_clear_bclk", s_bclk, 1);
    sync_clear = 1;
    @(negedge clock);
    sync_clear = 0;
    check("clear_bclk", s_bclk, 0);

    // asynchronous reset mid-period
    en = 0;
    @(negedge clock);
    en = 1;
    repeat (100) @(negedge clock);
    check("pre_rst_state", {s_bclk, s_rv}, 2'b11);
    #2 rst = 1;
    #1;
    check("rst_async", {t_os, t_mid, t_bit, bclk, rv}, 5'b0);
    check("rst_async_s", {s_os, s_mid, s_bit, s_bclk, s_rv}, 5'b0);
    @(negedge clock);
    rst = 0;
    first_tick(p, ps);
    check("rst_latency", p, 325);
    check("rst_latency_s", ps, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
